// File: rtl/cmd_frame_pkg.sv
// Shared types and defaults for the command frame manager and its CRC helper.
package cmd_frame_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARGS = 2'd1,
      CRC  = 2'd2
   } state_e;

   localparam logic [7:0] CRC_POLY_DEFAULT = 8'h07;
   localparam logic [7:0] CRC_INIT_DEFAULT = 8'h00;

   // Width of an index over n items, never less than one bit.
   function automatic int clog2(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/crc8_step.sv
// Combinational CRC-8 update over one byte, MSB-first, non-reflected.
module crc8_step #(
   parameter logic [7:0] CRC_POLY = 8'h07
) (
   input  logic [7:0] crc_in,
   input  logic [7:0] byte_in,
   output logic [7:0] crc_out
);

   logic [7:0] c;

   always_comb begin
      c = crc_in ^ byte_in;
      for (int i = 0; i < 8; i++) begin
         c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/cmd_frame_manager.sv
// Assembles cmd / N_ARGS args / CRC frames from a toggle byte strobe, checks CRC-8,
// enforces an inter-byte timeout and presents frames on a valid/ready output.
module cmd_frame_manager
   import cmd_frame_pkg::*;
#(
   parameter int unsigned N_ARGS         = 2,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter bit          DROP_BAD_CRC   = 1'b1,
   parameter logic [7:0]  CRC_POLY       = CRC_POLY_DEFAULT,
   parameter logic [7:0]  CRC_INIT       = CRC_INIT_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                en,
   input  logic [7:0]          in_byte,
   input  logic                byte_finished,
   output logic [7:0]          cmd,
   output logic [8*N_ARGS-1:0] args,
   output logic [7:0]          crc,
   output logic                crc_ok,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                frame_finished,
   output logic                crc_err,
   output logic                timeout,
   output logic                overrun,
   output logic                busy
);

   localparam int              IW       = clog2(int'(N_ARGS));
   localparam int              CW       = $clog2(TIMEOUT_CYCLES + 2);
   localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
   localparam logic [IW-1:0]   IDX_LAST = IW'(N_ARGS - 1);
   localparam logic [CW-1:0]   TMO_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_e              state_q, state_d;
   logic                bf_q;
   logic [IW-1:0]       idx_q, idx_d;
   logic [CW-1:0]       tcnt_q, tcnt_d;
   logic [7:0]          crc_run_q, crc_run_d;
   logic [7:0]          cmd_acc_q, cmd_acc_d;
   logic [8*N_ARGS-1:0] args_acc_q, args_acc_d;
   logic [7:0]          cmd_q, cmd_d;
   logic [8*N_ARGS-1:0] args_q, args_d;
   logic [7:0]          crc_q, crc_d;
   logic                crc_ok_q, crc_ok_d;
   logic                out_valid_q, out_valid_d;
   logic                frame_finished_q, frame_finished_d;
   logic                crc_err_q, crc_err_d;
   logic                timeout_q, timeout_d;
   logic                overrun_q, overrun_d;

   logic                accept;
   logic                crc_match;
   logic [7:0]          crc_seed;
   logic [7:0]          crc_next;

   assign accept    = en && (byte_finished != bf_q);
   assign crc_match = (in_byte == crc_run_q);
   assign crc_seed  = (state_q == IDLE) ? CRC_INIT : crc_run_q;

   crc8_step #(.CRC_POLY(CRC_POLY)) u_crc8_step (
      .crc_in  (crc_seed),
      .byte_in (in_byte),
      .crc_out (crc_next)
   );

   // NOTE: every variable gets its default before any branch, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_d          = state_q;
      idx_d            = idx_q;
      tcnt_d           = tcnt_q;
      crc_run_d        = crc_run_q;
      cmd_acc_d        = cmd_acc_q;
      args_acc_d       = args_acc_q;
      cmd_d            = cmd_q;
      args_d           = args_q;
      crc_d            = crc_q;
      crc_ok_d         = crc_ok_q;
      out_valid_d      = out_valid_q;
      frame_finished_d = 1'b0;
      crc_err_d        = 1'b0;
      timeout_d        = 1'b0;
      overrun_d        = 1'b0;

      if (out_valid_q && out_ready) out_valid_d = 1'b0;

      if (accept) begin
         tcnt_d = '0;
         unique case (state_q)
            IDLE: begin
               cmd_acc_d = in_byte;
               crc_run_d = crc_next;
               idx_d     = '0;
               state_d   = ARGS;
            end
            ARGS: begin
               args_acc_d[8*int'(idx_q) +: 8] = in_byte;
               crc_run_d = crc_next;
               idx_d     = idx_q + 1'b1;
               if (idx_q == IDX_LAST) state_d = CRC;
            end
            CRC: begin
               frame_finished_d = 1'b1;
               crc_err_d        = !crc_match;
               idx_d            = '0;
               state_d          = IDLE;
               if (crc_match || !DROP_BAD_CRC) begin
                  // A held frame that is not being taken this cycle wins over the new one.
                  if (out_valid_q && !out_ready) begin
                     overrun_d = 1'b1;
                  end else begin
                     cmd_d       = cmd_acc_q;
                     args_d      = args_acc_q;
                     crc_d       = in_byte;
                     crc_ok_d    = crc_match;
                     out_valid_d = 1'b1;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end else if (TMO_EN && en && (state_q != IDLE)) begin
         if (tcnt_q == TMO_LAST) begin
            timeout_d = 1'b1;
            tcnt_d    = '0;
            idx_d     = '0;
            state_d   = IDLE;
         end else begin
            tcnt_d = tcnt_q + 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   // NOTE: the frame buffers are ordinary flops and are cleared by reset so no stale frame appears after it.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q          <= IDLE;
         bf_q             <= 1'b0;
         idx_q            <= '0;
         tcnt_q           <= '0;
         crc_run_q        <= '0;
         cmd_acc_q        <= '0;
         args_acc_q       <= '0;
         cmd_q            <= '0;
         args_q           <= '0;
         crc_q            <= '0;
         crc_ok_q         <= 1'b0;
         out_valid_q      <= 1'b0;
         frame_finished_q <= 1'b0;
         crc_err_q        <= 1'b0;
         timeout_q        <= 1'b0;
         overrun_q        <= 1'b0;
      end else begin
         state_q          <= state_d;
         bf_q             <= byte_finished;
         idx_q            <= idx_d;
         tcnt_q           <= tcnt_d;
         crc_run_q        <= crc_run_d;
         cmd_acc_q        <= cmd_acc_d;
         args_acc_q       <= args_acc_d;
         cmd_q            <= cmd_d;
         args_q           <= args_d;
         crc_q            <= crc_d;
         crc_ok_q         <= crc_ok_d;
         out_valid_q      <= out_valid_d;
         frame_finished_q <= frame_finished_d;
         crc_err_q        <= crc_err_d;
         timeout_q        <= timeout_d;
         overrun_q        <= overrun_d;
      end
   end

   assign cmd            = cmd_q;
   assign args           = args_q;
   assign crc            = crc_q;
   assign crc_ok         = crc_ok_q;
   assign out_valid      = out_valid_q;
   assign frame_finished = frame_finished_q;
   assign crc_err        = crc_err_q;
   assign timeout        = timeout_q;
   assign overrun        = overrun_q;
   assign busy           = (state_q != IDLE);

endmodule

// File: doc/cmd_frame_manager.md
Name: cmd_frame_manager

Overview:
Parametrised successor to the fixed cmd/arg1/arg2/crc command assembler. It receives bytes over the toggle-style `byte_finished` handshake and assembles frames of the form cmd, N_ARGS argument bytes, then a CRC byte. It checks the CRC-8, enforces an inter-byte timeout, and hands completed frames downstream over a valid/ready interface. It sits between the serial byte receiver and the cartridge command decoder.

Parameters:
- N_ARGS, 2, number of argument bytes per frame; legal range 1..16.
- TIMEOUT_CYCLES, 1024, idle clocks allowed inside a partial frame before it is aborted; 0 disables the timeout.
- DROP_BAD_CRC, 1, 1 = frames with a bad CRC are not delivered; 0 = they are delivered with crc_ok=0.
- CRC_POLY, 8'h07, CRC-8 polynomial.
- CRC_INIT, 8'h00, CRC register seed applied at each cmd byte.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  accept enable.
- in_byte  in  8  data byte; must be stable when byte_finished toggles.
- byte_finished  in  1  toggle strobe; every level change marks one new byte.
- cmd  out  8  command byte of the delivered frame.
- args  out  8*N_ARGS  argument bytes; arg1 is in [7:0], argK is in [8K-1:8K-8].
- crc  out  8  received CRC byte.
- crc_ok  out  1  received CRC equals the computed CRC; qualified by out_valid.
- out_valid  out  1  a delivered frame is held on cmd/args/crc.
- out_ready  in  1  consumer accepts the frame.
- frame_finished  out  1  1-cycle pulse on every CRC-byte accept, good or bad.
- crc_err  out  1  1-cycle pulse on a CRC mismatch.
- timeout  out  1  1-cycle pulse when a partial frame is aborted.
- overrun  out  1  1-cycle pulse when a completed frame is dropped because out_valid is still held.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; bf_q=0; all outputs 0, args=0; timeout counter=0; arg index=0.
- Toggle detect: bf_q <= byte_finished on every edge, regardless of en. A byte is accepted at edge E if en=1 and byte_finished != bf_q. in_byte is sampled at that same edge E.
- Toggles while en=0 are discarded, never replayed. With en=0 the state and timeout counter are frozen.
- FSM states:
  - IDLE: on accept, store cmd; crc_run = f(CRC_INIT ^ byte); idx=0; go to ARGS.
  - ARGS: on accept, store arg[idx]; update crc_run; idx++. When idx reaches N_ARGS-1 on this accept, go to CRC.
  - CRC: on accept, compare the byte with crc_run, pulse frame_finished, then deliver or drop the frame and return to IDLE.
- CRC-8: MSB-first, non-reflected, no final XOR, updated one byte per accept. Worked value: {01,02,03} gives 8'h48.
- Delivery latency: out_valid, cmd, args, crc and crc_ok are registered at edge E of the CRC-byte accept, so they are visible in the cycle after E. The pulses frame_finished, crc_err and overrun are asserted in that same cycle.
- Output handshake: out_valid stays high, with its data held, until a cycle with out_valid && out_ready. It clears on that edge unless a new frame is delivered at the same edge; in that case the new frame is loaded and out_valid stays 1.
- Overrun: a frame completes while out_valid=1 and out_ready=0. Then overrun is pulsed, the new frame is dropped and the held frame is kept.
- Bad CRC:
  - Always pulses crc_err.
  - DROP_BAD_CRC=1: out_valid is not raised.
  - DROP_BAD_CRC=0: the frame is delivered with crc_ok=0.
- Timeout: the counter clears on each accept and counts while busy && en. When it reaches TIMEOUT_CYCLES, timeout is pulsed, state goes to IDLE and the partial data is discarded; out_valid is unaffected.
- Reset mid-frame: the partial frame is lost and any held frame is cleared.

Decomposition:
- cmd_frame_pkg holds:
  - the state encoding (IDLE=2'd0, ARGS=2'd1, CRC=2'd2);
  - CRC_POLY_DEFAULT;
  - CRC_INIT_DEFAULT;
  - the arg-index width function clog2(N_ARGS).
- One sub-module, crc8_step: a combinational single-byte CRC-8 update parameterised by CRC_POLY, with ports crc_in, byte_in and crc_out.

Test Plan:
- N_ARGS=2, toggles carrying 01,02,03,48, out_ready=1 → cmd=01, args=16'h0302, crc=48, crc_ok=1, one frame_finished pulse, out_valid high for exactly 1 cycle.
- Same frame with a CRC byte of 49, DROP_BAD_CRC=1 → crc_err pulse and frame_finished pulse, out_valid stays 0. With DROP_BAD_CRC=0 → out_valid=1 with crc_ok=0.
- out_ready=0, two good frames back-to-back → first frame held, overrun pulses once; out_ready=1 then releases the first frame's data.
- TIMEOUT_CYCLES=16, send the cmd byte only, then idle → timeout pulses 16 clocks after the accept and busy=0. A fresh 01,02,03,48 frame then completes normally.
- en=0 during 2 toggles mid-frame, then en=1 and 2 more toggles → the disabled bytes are ignored and the frame completes using only the enabled bytes.
- Drop reset for 2 clocks while in ARGS with out_valid=1 → all outputs 0 immediately (asynchronously). The next frame decodes correctly from IDLE.
